// File: rtl/vend_pkg.sv
// Shared types and coin decoding for the multi-item vending controller.
// Coin values are passed in so each controller instance can set its own denominations.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } vend_state_t;

  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_A_CODE = 2'b01;
  localparam logic [1:0] COIN_B_CODE = 2'b10;
  localparam logic [1:0] COIN_C_CODE = 2'b11;

  function automatic int unsigned coin_value(input logic [1:0] code,
                                             input int unsigned val_a,
                                             input int unsigned val_b,
                                             input int unsigned val_c);
    int unsigned v;
    case (code)
      COIN_A_CODE: v = val_a;
      COIN_B_CODE: v = val_b;
      COIN_C_CODE: v = val_c;
      default:     v = 0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters, reloaded only by reset, with an empty flag per channel.
// The empty vector is padded to a power of two so out-of-range indices read as empty.
module vend_stock_bank
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS  = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 2,
  parameter int IDX_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dec,
  input  logic [IDX_W-1:0]      dec_idx,
  output logic [2**IDX_W-1:0]   empty
);

  genvar gi;
  generate
    for (gi = 0; gi < 2**IDX_W; gi++) begin : g_item
      if (gi < NUM_ITEMS) begin : g_cnt
        logic [STOCK_W-1:0] cnt_reg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            cnt_reg <= STOCK_W'(STOCK_INIT);
          end else if (dec && (dec_idx == IDX_W'(gi)) && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        assign empty[gi] = (cnt_reg == '0);
      end else begin : g_pad
        assign empty[gi] = 1'b1;
      end
    end
  endgenerate

endmodule

// File: rtl/vend_ctrl.sv
// Multi-item vending controller: credit accumulation, common-price vend,
// serial change in COIN_A units and cancel/refund, all outputs registered.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int          CREDIT_W   = 8,
  parameter int unsigned COIN_A     = 5,
  parameter int unsigned COIN_B     = 10,
  parameter int unsigned COIN_C     = 25,
  parameter int unsigned PRICE      = 15,
  parameter int          NUM_ITEMS  = 4,
  parameter int          STOCK_W    = 4,
  parameter int          STOCK_INIT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   d_in,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] sel_item,
  input  logic                         cancel,
  output logic [CREDIT_W-1:0]          credit,
  output logic                         vend,
  output logic [$clog2(NUM_ITEMS)-1:0] vend_item,
  output logic                         change_pulse,
  output logic                         coin_reject,
  output logic                         sold_out,
  output logic                         busy
);

  localparam int                 IDX_W      = $clog2(NUM_ITEMS);
  localparam int unsigned        CREDIT_MAX = (2**CREDIT_W) - 1;
  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] COIN_A_C  = CREDIT_W'(COIN_A);

  // Change is paid only in COIN_A units, so every other amount must divide evenly.
  generate
    if (NUM_ITEMS < 2 || COIN_A == 0 || (COIN_B % COIN_A) != 0 ||
        (COIN_C % COIN_A) != 0 || (PRICE % COIN_A) != 0 || PRICE > CREDIT_MAX) begin : g_bad_params
      $fatal(1, "vend_ctrl: invalid coin/price/item parameters");
    end
  endgenerate

  vend_state_t          state_reg;
  logic [CREDIT_W-1:0]  credit_reg;
  logic                 vend_reg;
  logic [IDX_W-1:0]     vend_item_reg;
  logic                 change_reg;
  logic                 coin_reject_reg;
  logic                 sold_out_reg;
  logic                 busy_reg;

  logic [2**IDX_W-1:0]  empty;
  logic [CREDIT_W-1:0]  coin_val;
  logic [CREDIT_W:0]    coin_sum;
  logic                 accepting;
  logic                 cancel_acc;
  logic                 sel_try;
  logic                 sel_empty;
  logic                 sel_sold;
  logic                 sel_ok;
  logic                 coin_present;
  logic                 coin_acc;

  vend_stock_bank #(
    .NUM_ITEMS  (NUM_ITEMS),
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (STOCK_INIT),
    .IDX_W      (IDX_W)
  ) u_stock (
    .clk     (clk),
    .rst_n   (rst_n),
    .dec     (sel_ok),
    .dec_idx (sel_item),
    .empty   (empty)
  );

  // Priority cancel > selection > coin; a coin only lands when nothing above it acted.
  always_comb begin
    coin_val     = CREDIT_W'(coin_value(d_in, COIN_A, COIN_B, COIN_C));
    coin_sum     = {1'b0, credit_reg} + {1'b0, coin_val};
    accepting    = (state_reg == ST_IDLE) || (state_reg == ST_CREDIT);
    cancel_acc   = cancel && (state_reg == ST_CREDIT);
    sel_try      = accepting && sel_valid && !cancel_acc;
    sel_empty    = empty[sel_item];
    sel_sold     = sel_try && sel_empty;
    sel_ok       = sel_try && !sel_empty && (credit_reg >= PRICE_C);
    coin_present = (d_in != COIN_NONE);
    coin_acc     = coin_present && accepting && !cancel_acc && !sel_ok && !coin_sum[CREDIT_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      credit_reg      <= '0;
      vend_reg        <= 1'b0;
      vend_item_reg   <= '0;
      change_reg      <= 1'b0;
      coin_reject_reg <= 1'b0;
      sold_out_reg    <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      vend_reg        <= 1'b0;
      change_reg      <= 1'b0;
      coin_reject_reg <= coin_present && !coin_acc;
      sold_out_reg    <= sel_sold;

      case (state_reg)
        ST_IDLE, ST_CREDIT: begin
          if (cancel_acc) begin
            // First refund pulse goes out on the same edge that enters CHANGE.
            state_reg  <= ST_CHANGE;
            busy_reg   <= 1'b1;
            change_reg <= 1'b1;
            credit_reg <= credit_reg - COIN_A_C;
          end else if (sel_ok) begin
            state_reg     <= ST_VEND;
            busy_reg      <= 1'b1;
            vend_reg      <= 1'b1;
            vend_item_reg <= sel_item;
            credit_reg    <= credit_reg - PRICE_C;
          end else if (coin_acc) begin
            state_reg  <= ST_CREDIT;
            credit_reg <= coin_sum[CREDIT_W-1:0];
          end
        end

        ST_VEND: begin
          if (credit_reg != '0) begin
            state_reg  <= ST_CHANGE;
            change_reg <= 1'b1;
            credit_reg <= credit_reg - COIN_A_C;
          end else begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end

        ST_CHANGE: begin
          if (credit_reg == '0) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            change_reg <= 1'b1;
            credit_reg <= credit_reg - COIN_A_C;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign credit       = credit_reg;
  assign vend         = vend_reg;
  assign vend_item    = vend_item_reg;
  assign change_pulse = change_reg;
  assign coin_reject  = coin_reject_reg;
  assign sold_out     = sold_out_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed scenarios plus randomized traffic against a
// transcript model that schedules each sale/refund as a list of future outputs.
module tb_vend_ctrl;

  localparam int NUM_ITEMS  = 4;
  localparam int COIN_A     = 5;
  localparam int PRICE      = 15;
  localparam int CREDIT_MAX = 255;
  localparam int STOCK_INIT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] d_in = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = 2'b00;
  logic       cancel = 1'b0;
  logic [7:0] credit;
  logic       vend;
  logic [1:0] vend_item;
  logic       change_pulse;
  logic       coin_reject;
  logic       sold_out;
  logic       busy;

  vend_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .d_in         (d_in),
    .sel_valid    (sel_valid),
    .sel_item     (sel_item),
    .cancel       (cancel),
    .credit       (credit),
    .vend         (vend),
    .vend_item    (vend_item),
    .change_pulse (change_pulse),
    .coin_reject  (coin_reject),
    .sold_out     (sold_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  logic [14:0] obs_vec;
  logic [14:0] exp_vec;
  assign obs_vec = {credit, vend, vend_item, change_pulse, coin_reject, sold_out, busy};

  typedef struct {
    bit vend;
    bit chg;
    int cr;
    bit busy;
  } out_t;

  out_t sched[$];
  int   m_credit;
  bit   m_busy;
  int   m_item;
  int   m_stock[NUM_ITEMS];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [5:0] stim(input int d, input int sv, input int si, input int c);
    return {d[1:0], sv[0], si[1:0], c[0]};
  endfunction

  task automatic model_reset();
    sched.delete();
    m_credit = 0;
    m_busy   = 0;
    m_item   = 0;
    for (int k = 0; k < NUM_ITEMS; k++) m_stock[k] = STOCK_INIT;
    exp_vec = '0;
  endtask

  // Drive one cycle of inputs, predict the outputs after the edge, then step the clock.
  task automatic drive_cycle(input logic [5:0] s);
    logic [1:0] d;
    logic       sv;
    logic [1:0] si;
    logic       c;
    int         cv, rem, idx;
    bit         rej, so, blocked;
    out_t       nxt;
    {d, sv, si, c} = s;
    d_in = d; sel_valid = sv; sel_item = si; cancel = c;
    cv = (d == 2'd1) ? 5 : (d == 2'd2) ? 10 : (d == 2'd3) ? 25 : 0;
    rej = 0; so = 0; blocked = 0;
    nxt = '{vend: 1'b0, chg: 1'b0, cr: m_credit, busy: 1'b0};
    if (m_busy) begin
      rej = (d != 2'd0);
      if (sched.size() > 0) nxt = sched.pop_front();
    end else begin
      if (c && m_credit > 0) begin
        $display("txn: cancel refund %0d", m_credit);
        for (int k = 1; k <= m_credit / COIN_A; k++)
          sched.push_back('{1'b0, 1'b1, m_credit - k * COIN_A, 1'b1});
        blocked = 1;
      end else if (sv) begin
        idx = int'(si);
        if (idx >= NUM_ITEMS || m_stock[idx] == 0) begin
          so = 1;
          $display("txn: sold out item %0d", idx);
        end else if (m_credit >= PRICE) begin
          rem = m_credit - PRICE;
          $display("txn: sale item %0d change %0d", idx, rem);
          sched.push_back('{1'b1, 1'b0, rem, 1'b1});
          for (int k = 1; k <= rem / COIN_A; k++)
            sched.push_back('{1'b0, 1'b1, rem - k * COIN_A, 1'b1});
          m_stock[idx]--;
          m_item  = idx;
          blocked = 1;
        end
      end
      if (d != 2'd0) begin
        if (blocked || m_credit + cv > CREDIT_MAX) rej = 1;
        else nxt.cr = m_credit + cv;
      end
      if (sched.size() > 0) nxt = sched.pop_front();
    end
    m_credit = nxt.cr;
    m_busy   = nxt.busy;
    exp_vec  = {8'(nxt.cr), nxt.vend, 2'(m_item), nxt.chg, rej, so, nxt.busy};
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    d_in = 2'b00; sel_valid = 1'b0; sel_item = 2'b00; cancel = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    assert_reset();
    n_cmp++;
    if (obs_vec !== exp_vec) begin
      n_err++;
      $display("FAIL reset: got credit=%0d flags=%b want credit=%0d flags=%b",
               obs_vec[14:7], obs_vec[6:0], exp_vec[14:7], exp_vec[6:0]);
    end
    release_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(6'd0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: got credit=%0d flags=%b want credit=%0d flags=%b",
                 i, obs_vec[14:7], obs_vec[6:0], exp_vec[14:7], exp_vec[6:0]);
      end
    end
  endtask

  task automatic test_vend_change();
    logic [5:0] q[$];
    q = '{stim(2, 0, 0, 0), stim(2, 0, 0, 0), stim(0, 1, 1, 0)};
    for (int k = 0; k < 4; k++) q.push_back(6'd0);
    foreach (q[i]) begin
      drive_cycle(q[i]);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL vend_change[%0d]: got credit=%0d flags=%b want credit=%0d flags=%b",
                 i, obs_vec[14:7], obs_vec[6:0], exp_vec[14:7], exp_vec[6:0]);
      end
    end
  endtask

  task automatic test_cancel();
    logic [5:0] q[$];
    q = '{stim(3, 0, 0, 0), stim(0, 0, 0, 1)};
    for (int k = 0; k < 8; k++) q.push_back(6'd0);
    foreach (q[i]) begin
      drive_cycle(q[i]);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL cancel[%0d]: got credit=%0d flags=%b want credit=%0d flags=%b",
                 i, obs_vec[14:7], obs_vec[6:0], exp_vec[14:7], exp_vec[6:0]);
      end
    end
  endtask

  task automatic test_sold_out();
    logic [5:0] q[$];
    q = '{stim(2, 0, 0, 0), stim(1, 0, 0, 0), stim(0, 1, 2, 0), stim(0, 0, 0, 0),
          stim(2, 0, 0, 0), stim(1, 0, 0, 0), stim(0, 1, 2, 0), stim(0, 0, 0, 0),
          stim(2, 0, 0, 0), stim(1, 0, 0, 0), stim(0, 1, 2, 0), stim(0, 0, 0, 0),
          stim(0, 1, 2, 0), stim(0, 0, 0, 1)};
    for (int k = 0; k < 6; k++) q.push_back(6'd0);
    foreach (q[i]) begin
      drive_cycle(q[i]);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL sold_out[%0d]: got credit=%0d flags=%b want credit=%0d flags=%b",
                 i, obs_vec[14:7], obs_vec[6:0], exp_vec[14:7], exp_vec[6:0]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [5:0] q[$];
    for (int k = 0; k < 10; k++) q.push_back(stim(3, 0, 0, 0));
    q.push_back(stim(2, 0, 0, 0));
    q.push_back(stim(1, 0, 0, 0));
    q.push_back(stim(1, 0, 0, 0));
    q.push_back(stim(0, 0, 0, 1));
    q.push_back(stim(1, 0, 0, 0));
    q.push_back(stim(0, 0, 0, 1));
    for (int k = 0; k < 56; k++) q.push_back(6'd0);
    foreach (q[i]) begin
      drive_cycle(q[i]);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL overflow[%0d]: got credit=%0d flags=%b want credit=%0d flags=%b",
                 i, obs_vec[14:7], obs_vec[6:0], exp_vec[14:7], exp_vec[6:0]);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [5:0] q[$];
    q = '{stim(2, 0, 0, 0), stim(1, 1, 0, 0), stim(2, 1, 0, 1)};
    for (int k = 0; k < 5; k++) q.push_back(6'd0);
    foreach (q[i]) begin
      drive_cycle(q[i]);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL same_cycle[%0d]: got credit=%0d flags=%b want credit=%0d flags=%b",
                 i, obs_vec[14:7], obs_vec[6:0], exp_vec[14:7], exp_vec[6:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] q[$];
    q = '{stim(2, 0, 0, 0), stim(1, 0, 0, 0), stim(2, 1, 3, 0), stim(3, 1, 3, 1),
          stim(3, 0, 0, 0), stim(0, 1, 3, 0), stim(0, 0, 0, 1), stim(1, 0, 0, 1),
          stim(0, 0, 0, 0), stim(1, 1, 3, 0), stim(0, 0, 0, 1)};
    for (int k = 0; k < 4; k++) q.push_back(6'd0);
    foreach (q[i]) begin
      drive_cycle(q[i]);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got credit=%0d flags=%b want credit=%0d flags=%b",
                 i, obs_vec[14:7], obs_vec[6:0], exp_vec[14:7], exp_vec[6:0]);
      end
    end
  endtask

  task automatic test_reset_mid_change();
    logic [5:0] q[$];
    q = '{stim(2, 0, 0, 0), stim(2, 0, 0, 0), stim(0, 0, 0, 1), stim(0, 0, 0, 0)};
    foreach (q[i]) begin
      drive_cycle(q[i]);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL mid_reset_pre[%0d]: got credit=%0d flags=%b want credit=%0d flags=%b",
                 i, obs_vec[14:7], obs_vec[6:0], exp_vec[14:7], exp_vec[6:0]);
      end
    end
    assert_reset();
    n_cmp++;
    if (obs_vec !== exp_vec) begin
      n_err++;
      $display("FAIL mid_reset_now: got credit=%0d flags=%b want credit=%0d flags=%b",
               obs_vec[14:7], obs_vec[6:0], exp_vec[14:7], exp_vec[6:0]);
    end
    release_reset();
    // Item 2 was emptied earlier; two sales and a refusal prove the reload.
    q = '{stim(0, 0, 0, 0), stim(0, 0, 0, 0), stim(0, 0, 0, 0),
          stim(3, 0, 0, 0), stim(0, 1, 2, 0), stim(0, 0, 0, 0), stim(0, 0, 0, 0),
          stim(0, 0, 0, 0), stim(3, 0, 0, 0), stim(0, 1, 2, 0), stim(0, 0, 0, 0),
          stim(0, 0, 0, 0), stim(0, 0, 0, 0), stim(3, 0, 0, 0), stim(0, 1, 2, 0),
          stim(0, 0, 0, 1)};
    for (int k = 0; k < 7; k++) q.push_back(6'd0);
    foreach (q[i]) begin
      drive_cycle(q[i]);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL mid_reset_post[%0d]: got credit=%0d flags=%b want credit=%0d flags=%b",
                 i, obs_vec[14:7], obs_vec[6:0], exp_vec[14:7], exp_vec[6:0]);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int round = 0; round < 3; round++) begin
      assert_reset();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL random_reset[%0d]: got credit=%0d flags=%b want credit=%0d flags=%b",
                 round, obs_vec[14:7], obs_vec[6:0], exp_vec[14:7], exp_vec[6:0]);
      end
      release_reset();
      for (int i = 0; i < 200; i++) begin
        r = int'($urandom_range(0, 7));
        drive_cycle(stim((r < 4) ? 0 : r - 4,
                         ($urandom_range(0, 3) == 0) ? 1 : 0,
                         int'($urandom_range(0, 3)),
                         ($urandom_range(0, 15) == 0) ? 1 : 0));
        n_cmp++;
        if (obs_vec !== exp_vec) begin
          n_err++;
          $display("FAIL random[%0d.%0d]: got credit=%0d flags=%b want credit=%0d flags=%b",
                   round, i, obs_vec[14:7], obs_vec[6:0], exp_vec[14:7], exp_vec[6:0]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_vend_change();
    test_cancel();
    test_sold_out();
    test_overflow();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
